// File: rtl/mant_mul_seq_if.sv
// Operand/result bundle between operand unpacking, the sequential mantissa
// multiplier and normalisation/rounding.
`timescale 1ns/1ps
interface mant_mul_seq_if #(
   parameter int MANT_W = 53
);
   // start is a request that is sampled only while the multiplier is idle (busy=0).
   // a_in/b_in are captured on the same edge. Requests made while busy are dropped.
   // done pulses for one cycle, and p_out stays valid from then until the next done.
   logic                  start;
   logic [MANT_W-1:0]     a_in;
   logic [MANT_W-1:0]     b_in;
   logic                  busy;
   logic                  done;
   logic [2*MANT_W-1:0]   p_out;

   modport master (
      output start, a_in, b_in,
      input  busy, done, p_out
   );

   modport slave (
      input  start, a_in, b_in,
      output busy, done, p_out
   );
endinterface

// File: rtl/mant_mul_seq.sv
// Sequential 53x53 significand multiplier: one 16x16 multiplier, 16 limb-pair
// products accumulated into a 2*MANT_W-bit sum over 16 cycles.
`timescale 1ns/1ps
module v16x16 (
   input  logic [15:0] i_a,
   input  logic [15:0] i_b,
   output logic [31:0] o_p
);
   assign o_p = i_a * i_b;
endmodule

module mant_mul_seq #(
   parameter int MANT_W = 53
) (
   input  logic                clk,
   input  logic                rst,
   mant_mul_seq_if.slave       io_bus,
   output logic [0:0]          o_dbg_state
);
   localparam int PW = 2 * MANT_W;

   typedef enum logic {ST_IDLE = 1'b0, ST_MUL = 1'b1} state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic            w_accept;
   logic            w_step;
   logic            w_last;

   logic [63:0]     r_a;
   logic [63:0]     r_b;
   logic [PW-1:0]   r_acc;
   logic [PW-1:0]   r_p;
   logic [3:0]      r_k;
   logic            r_busy;
   logic            r_done;

   logic [15:0]     w_a_limb;
   logic [15:0]     w_b_limb;
   logic [31:0]     w_prod;
   logic [2:0]      w_shift;
   logic [PW-1:0]   w_term;
   logic [PW-1:0]   w_sum;

   // k[1:0] walks the a limbs, k[3:2] the b limbs
   assign w_a_limb = r_a[{r_k[1:0], 4'b0000} +: 16];
   assign w_b_limb = r_b[{r_k[3:2], 4'b0000} +: 16];

   v16x16 u_mul (
      .i_a (w_a_limb),
      .i_b (w_b_limb),
      .o_p (w_prod)
   );

   // Every partial sum is bounded by the final product, so truncating to PW is exact
   assign w_shift = {1'b0, r_k[1:0]} + {1'b0, r_k[3:2]};
   assign w_term  = PW'(w_prod) << {w_shift, 4'b0000};
   assign w_sum   = r_acc + w_term;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_step      = 1'b0;
      w_last      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (io_bus.start) begin
               w_accept    = 1'b1;
               w_state_nxt = ST_MUL;
            end
         end
         ST_MUL: begin
            w_step = 1'b1;
            if (r_k == 4'd15) begin
               w_last      = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a    <= '0;
         r_b    <= '0;
         r_acc  <= '0;
         r_p    <= '0;
         r_k    <= '0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_accept) begin
            r_a    <= 64'(io_bus.a_in);
            r_b    <= 64'(io_bus.b_in);
            r_acc  <= '0;
            r_k    <= '0;
            r_busy <= 1'b1;
         end else if (w_step) begin
            r_acc <= w_sum;
            r_k   <= r_k + 4'd1;
            if (w_last) begin
               r_p    <= w_sum;
               r_done <= 1'b1;
               r_busy <= 1'b0;
            end
         end
      end
   end

   assign io_bus.busy  = r_busy;
   assign io_bus.done  = r_done;
   assign io_bus.p_out = r_p;
   assign o_dbg_state  = r_state;
endmodule

// File: tb/tb_mant_mul_seq.sv
// Self-checking bench for mant_mul_seq: directed corner cases plus random
// operands, checked against a plain wide-multiply reference.
`timescale 1ns/1ps
module tb_mant_mul_seq;
   localparam int W  = 53;
   localparam int PW = 2 * W;

   logic clk;
   logic rst;
   logic [0:0] dbg_state;

   mant_mul_seq_if #(.MANT_W(W)) bus ();

   mant_mul_seq #(.MANT_W(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .io_bus      (bus.slave),
      .o_dbg_state (dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   logic [PW-1:0] exp_q[$];

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [PW-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [127:0] f;
      f = 128'(a) * 128'(b);
      return f[PW-1:0];
   endfunction

   function automatic logic [W-1:0] rand_op();
      return W'({$urandom, $urandom});
   endfunction

   // Scoreboard: every done pulse must retire the oldest outstanding expectation
   always @(negedge clk) begin
      if (!rst && bus.done) begin
         if (exp_q.size() == 0) check("spurious_done", 1, 0);
         else check("p_out", bus.p_out, exp_q.pop_front());
      end
   end

   // Issue one request at the current negedge; start stays high (with junk operands) for 'hold' extra cycles
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int hold,
                         output int lat, output int bcnt);
      bus.start = 1'b1;
      bus.a_in  = a;
      bus.b_in  = b;
      exp_q.push_back(ref_mul(a, b));
      lat  = 0;
      bcnt = 0;
      while (1) begin
         @(negedge clk);
         lat++;
         if (lat > hold) bus.start = 1'b0;
         else begin
            bus.a_in = rand_op();
            bus.b_in = rand_op();
         end
         if (bus.busy) bcnt++;
         if (bus.done) break;
         if (lat >= 40) begin
            check("done_timeout", 0, 1);
            break;
         end
      end
   endtask

   task automatic op_checked(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
      int lat, bcnt;
      run_op(a, b, hold, lat, bcnt);
      check({tag, "_latency"}, 128'(lat - 1), 16);
      check({tag, "_busy_cycles"}, 128'(bcnt), 16);
   endtask

   task automatic idle_check(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         check({tag, "_busy"}, bus.busy, 0);
         check({tag, "_done"}, bus.done, 0);
      end
   endtask

   initial begin
      int lat, bcnt;
      logic [PW-1:0] held;
      rst = 1'b1;
      bus.start = 1'b0;
      bus.a_in  = '0;
      bus.b_in  = '0;
      #3;
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_p_out", bus.p_out, 0);
      @(negedge clk);
      #2 rst = 1'b0;
      idle_check("idle", 4);

      // Trivial product, then single-cycle done and held result
      op_checked("one", 1, 1, 0);
      check("one_p", bus.p_out, 1);
      @(negedge clk);
      check("one_done_pulse", bus.done, 0);
      check("one_p_held", bus.p_out, 1);

      op_checked("max", {W{1'b1}}, {W{1'b1}}, 0);
      check("max_p", bus.p_out, 106'h3FFFFFFFFFFFFC0000000000001);
      @(negedge clk);

      op_checked("hidden", W'(1) << 52, W'(1) << 52, 0);
      check("hidden_p", bus.p_out, 106'(1) << 104);
      @(negedge clk);
      op_checked("carry", 53'h1_2345_6789_ABCD, 53'h1F_FFFF_FFFF_FFFF, 0);
      @(negedge clk);

      // start held through busy with other operands must not disturb the first result
      op_checked("hold", 53'h0F_0F0F_0F0F_0F0F, 53'h10_0000_0000_0001, 10);
      held = bus.p_out;
      check("hold_p", held, ref_mul(53'h0F_0F0F_0F0F_0F0F, 53'h10_0000_0000_0001));
      idle_check("after_hold", 20);
      check("hold_p_kept", bus.p_out, held);

      // start in the done cycle: accepted with no gap
      run_op(53'h1A_BCDE_F012_3456, 53'h15_5555_5555_5555, 0, lat, bcnt);
      check("b2b_first_latency", 128'(lat - 1), 16);
      op_checked("b2b_second", 53'h10_0000_0000_0003, 53'h1F_0000_FFFF_0000, 0);
      @(negedge clk);

      // Asynchronous reset at step 8 abandons the operation
      bus.start = 1'b1;
      bus.a_in  = 53'h1F_FFFF_0000_FFFF;
      bus.b_in  = 53'h13_3333_3333_3333;
      @(negedge clk);
      bus.start = 1'b0;
      for (int i = 0; i < 8; i++) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_busy", bus.busy, 0);
      check("mid_rst_done", bus.done, 0);
      check("mid_rst_p_out", bus.p_out, 0);
      check("mid_rst_state", dbg_state, 0);
      @(negedge clk);
      #2 rst = 1'b0;
      idle_check("post_rst", 20);
      check("post_rst_p_out", bus.p_out, 0);
      @(negedge clk);
      op_checked("three_five", 3, 5, 0);
      check("three_five_p", bus.p_out, 15);
      @(negedge clk);

      // Random operands, occasionally forcing the hidden bit on
      for (int n = 0; n < 24; n++) begin
         logic [W-1:0] ra, rb;
         ra = rand_op();
         rb = rand_op();
         if ($urandom_range(0, 1) == 1) begin
            ra[W-1] = 1'b1;
            rb[W-1] = 1'b1;
         end
         op_checked("rand", ra, rb, $urandom_range(0, 12));
         if ($urandom_range(0, 2) == 0) @(negedge clk);
      end

      @(negedge clk);
      check("queue_empty", 128'(exp_q.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
